// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch mode controller: state encoding and
// default sizing of the time word and the lap store.
package stopwatch_pkg;

  localparam int TIME_W_DEF    = 32;
  localparam int LAP_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_LAP    = 3'd2,
    ST_STOP   = 3'd3,
    ST_RECALL = 3'd4
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level. The history register
// resets high so a button held through reset does not produce a pulse.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic prev_q;

  // Remember last cycle's level; forced high during reset.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= btn;
  end

  assign pulse = btn & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: turns button pulses into counter enable/clear,
// captures lap times into a small circular store and selects the displayed
// time word.
//
// Handshake note: there is no valid/ready channel here. Each button pulse is a
// single-cycle event; at most one pulse (priority ss > lr > rc) is acted on per
// cycle and the others in that cycle are discarded, never queued.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TIME_W    = TIME_W_DEF,
  parameter int LAP_DEPTH = LAP_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         btn_ss,
  input  logic                         btn_lr,
  input  logic                         btn_rc,
  input  logic [TIME_W-1:0]            cnt_time,
  output logic                         run_en,
  output logic                         cnt_clr,
  output logic [TIME_W-1:0]            disp_time,
  output logic                         lap_mode,
  output logic [$clog2(LAP_DEPTH)-1:0] lap_idx,
  output logic [$clog2(LAP_DEPTH):0]   lap_cnt,
  output logic                         lap_full,
  output state_t                       dbg_state
);

  localparam int IW = $clog2(LAP_DEPTH);
  localparam int CW = IW + 1;

  logic ss_raw, lr_raw, rc_raw;
  logic ss_p, lr_p, rc_p;

  btn_edge u_edge_ss (.clk(clk), .reset(reset), .btn(btn_ss), .pulse(ss_raw));
  btn_edge u_edge_lr (.clk(clk), .reset(reset), .btn(btn_lr), .pulse(lr_raw));
  btn_edge u_edge_rc (.clk(clk), .reset(reset), .btn(btn_rc), .pulse(rc_raw));

  // Single winner per cycle.
  assign ss_p = ss_raw;
  assign lr_p = lr_raw & ~ss_raw;
  assign rc_p = rc_raw & ~ss_raw & ~lr_raw;

  state_t          state_q, state_d;
  logic [IW-1:0]   wr_ptr_q;
  logic [CW-1:0]   lap_cnt_q;
  logic [IW-1:0]   lap_idx_q, idx_d;
  logic            cnt_clr_q;
  logic            do_capture, do_clear;
  logic [TIME_W-1:0] lap_q [LAP_DEPTH];
  logic [IW-1:0]   last_ptr, rd_ptr;
  logic            idx_last;

  assign last_ptr = wr_ptr_q - IW'(1);
  assign rd_ptr   = wr_ptr_q - lap_cnt_q[IW-1:0] + lap_idx_q;
  assign idx_last = ({1'b0, lap_idx_q} == (lap_cnt_q - CW'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus capture/clear strobes and recall index update.
  always_comb begin
    state_d    = state_q;
    do_capture = 1'b0;
    do_clear   = 1'b0;
    idx_d      = lap_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (ss_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ss_p) begin
          state_d = ST_STOP;
        end else if (lr_p) begin
          do_capture = 1'b1;
          state_d    = ST_LAP;
        end
      end
      ST_LAP: begin
        if (ss_p)      state_d = ST_STOP;
        else if (lr_p) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (ss_p) begin
          state_d = ST_RUN;
        end else if (lr_p) begin
          do_clear = 1'b1;
          idx_d    = '0;
          state_d  = ST_IDLE;
        end else if (rc_p && (lap_cnt_q != '0)) begin
          idx_d   = '0;
          state_d = ST_RECALL;
        end
      end
      ST_RECALL: begin
        if (ss_p || lr_p) begin
          idx_d   = '0;
          state_d = ST_STOP;
        end else if (rc_p) begin
          idx_d = idx_last ? '0 : lap_idx_q + IW'(1);
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lap store, pointers, counters and the registered clear pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      lap_cnt_q <= '0;
      lap_idx_q <= '0;
      cnt_clr_q <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_q[i] <= '0;
    end else begin
      cnt_clr_q <= do_clear;
      lap_idx_q <= idx_d;
      if (do_capture) begin
        lap_q[wr_ptr_q] <= cnt_time;
        wr_ptr_q        <= wr_ptr_q + IW'(1);
        if (lap_cnt_q != CW'(LAP_DEPTH)) lap_cnt_q <= lap_cnt_q + CW'(1);
      end
      if (do_clear) begin
        wr_ptr_q  <= '0;
        lap_cnt_q <= '0;
      end
    end
  end

  // Display source follows the current mode.
  always_comb begin
    disp_time = cnt_time;
    case (state_q)
      ST_LAP:    disp_time = lap_q[last_ptr];
      ST_RECALL: disp_time = lap_q[rd_ptr];
      default:   disp_time = cnt_time;
    endcase
  end

  assign run_en    = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign lap_mode  = (state_q == ST_LAP) || (state_q == ST_RECALL);
  assign cnt_clr   = cnt_clr_q;
  assign lap_idx   = lap_idx_q;
  assign lap_cnt   = lap_cnt_q;
  assign lap_full  = (lap_cnt_q == CW'(LAP_DEPTH));
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for the stopwatch mode controller.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_ss, btn_lr, btn_rc;
  logic [31:0] cnt_time;
  logic        run_en, cnt_clr, lap_mode, lap_full;
  logic [31:0] disp_time;
  logic [1:0]  lap_idx;
  logic [2:0]  lap_cnt;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_disp [5];
  logic [31:0] exp_idx  [5];

  stopwatch_ctrl #(.TIME_W(32), .LAP_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .btn_ss(btn_ss), .btn_lr(btn_lr), .btn_rc(btn_rc),
    .cnt_time(cnt_time),
    .run_en(run_en), .cnt_clr(cnt_clr), .disp_time(disp_time),
    .lap_mode(lap_mode), .lap_idx(lap_idx), .lap_cnt(lap_cnt),
    .lap_full(lap_full), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One idle cycle (button low) then a one-cycle press; 0=ss 1=lr 2=rc.
  task automatic press(input int b);
    step();
    case (b)
      0: btn_ss = 1'b1;
      1: btn_lr = 1'b1;
      default: btn_rc = 1'b1;
    endcase
    step();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    btn_rc = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},   32'(dbg_state), 32'(ST_IDLE));
    chk({tag, "_run_en"},  32'(run_en),   32'd0);
    chk({tag, "_cnt_clr"}, 32'(cnt_clr),  32'd0);
    chk({tag, "_lap_mode"},32'(lap_mode), 32'd0);
    chk({tag, "_lap_idx"}, 32'(lap_idx),  32'd0);
    chk({tag, "_lap_cnt"}, 32'(lap_cnt),  32'd0);
    chk({tag, "_lap_full"},32'(lap_full), 32'd0);
    chk({tag, "_disp"},    disp_time,     cnt_time);
  endtask

  initial begin
    exp_disp = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h2};
    exp_idx  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

    // Reset
    reset = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0; btn_rc = 1'b0;
    cnt_time = 32'h0000_0777;
    step(); step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // 1: start / stop
    press(0);
    chk("t1_run_en", 32'(run_en), 32'd1);
    chk("t1_state_run", 32'(dbg_state), 32'(ST_RUN));
    cnt_time = 32'h0000_0100; #1;
    chk("t1_disp_run", disp_time, 32'h0000_0100);
    press(0);
    chk("t1_run_en_off", 32'(run_en), 32'd0);
    chk("t1_state_stop", 32'(dbg_state), 32'(ST_STOP));
    cnt_time = 32'h0000_0042; #1;
    chk("t1_disp_stop", disp_time, 32'h0000_0042);

    // 2: lap freeze while counter keeps running
    press(0);
    cnt_time = 32'h0000_1234;
    press(1);
    chk("t2_lap_mode", 32'(lap_mode), 32'd1);
    chk("t2_disp_frozen", disp_time, 32'h0000_1234);
    cnt_time = 32'h0000_1300; step();
    chk("t2_disp_still", disp_time, 32'h0000_1234);
    chk("t2_run_en_lap", 32'(run_en), 32'd1);
    chk("t2_lap_cnt", 32'(lap_cnt), 32'd1);
    press(1);
    chk("t2_lap_mode_off", 32'(lap_mode), 32'd0);
    chk("t2_run_en", 32'(run_en), 32'd1);
    chk("t2_disp_live", disp_time, 32'h0000_1300);
    chk("t2_lap_cnt_nocap", 32'(lap_cnt), 32'd1);

    // 3: five more laps overwrite the oldest entries
    for (int i = 1; i <= 5; i++) begin
      cnt_time = 32'(i);
      press(1);
      chk($sformatf("t3_lap_disp%0d", i), disp_time, 32'(i));
      cnt_time = 32'h0000_0900 + 32'(i);
      press(1);
    end
    chk("t3_lap_cnt", 32'(lap_cnt), 32'd4);
    chk("t3_lap_full", 32'(lap_full), 32'd1);
    press(0);
    chk("t3_stop", 32'(dbg_state), 32'(ST_STOP));
    for (int i = 0; i < 5; i++) begin
      press(2);
      chk($sformatf("t3_rc_state%0d", i), 32'(dbg_state), 32'(ST_RECALL));
      chk($sformatf("t3_rc_disp%0d", i), disp_time, exp_disp[i]);
      chk($sformatf("t3_rc_idx%0d", i), 32'(lap_idx), exp_idx[i]);
      chk($sformatf("t3_rc_mode%0d", i), 32'(lap_mode), 32'd1);
    end
    press(2);
    chk("t3_rc_idx_wrap1", 32'(lap_idx), 32'd1);
    press(1);
    chk("t3_rc_exit_state", 32'(dbg_state), 32'(ST_STOP));
    chk("t3_rc_exit_idx", 32'(lap_idx), 32'd0);
    chk("t3_rc_exit_clr", 32'(cnt_clr), 32'd0);
    chk("t3_rc_exit_run", 32'(run_en), 32'd0);
    chk("t3_rc_exit_cnt", 32'(lap_cnt), 32'd4);

    // 4: clear from STOP, recall with no laps
    press(1);
    chk("t4_clr_pulse", 32'(cnt_clr), 32'd1);
    chk("t4_lap_cnt", 32'(lap_cnt), 32'd0);
    chk("t4_lap_full", 32'(lap_full), 32'd0);
    chk("t4_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    step();
    chk("t4_clr_gone", 32'(cnt_clr), 32'd0);
    press(1);
    chk("t4_idle_lr_ign", 32'(dbg_state), 32'(ST_IDLE));
    chk("t4_idle_lr_noclr", 32'(cnt_clr), 32'd0);
    press(0); press(0);
    press(2);
    chk("t4_rc_empty_state", 32'(dbg_state), 32'(ST_STOP));
    chk("t4_rc_empty_mode", 32'(lap_mode), 32'd0);

    // 5: ss and lr in the same cycle while running
    press(0);
    step();
    btn_ss = 1'b1; btn_lr = 1'b1;
    step();
    btn_ss = 1'b0; btn_lr = 1'b0;
    chk("t5_both_state", 32'(dbg_state), 32'(ST_STOP));
    chk("t5_both_nocap", 32'(lap_cnt), 32'd0);
    chk("t5_both_mode", 32'(lap_mode), 32'd0);

    // 5b: button held through reset release gives no pulse
    btn_ss = 1'b1; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step(); step();
    chk("t5_held_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("t5_held_run", 32'(run_en), 32'd0);
    btn_ss = 1'b0;

    // 6: reset while in RECALL
    press(0);
    cnt_time = 32'h0000_00AA;
    press(1);
    press(0);
    press(2);
    chk("t6_in_recall", 32'(dbg_state), 32'(ST_RECALL));
    chk("t6_recall_disp", disp_time, 32'h0000_00AA);
    reset = 1'b1; cnt_time = 32'h0000_0055;
    step();
    chk_reset_vals("t6_rst_recall");
    reset = 1'b0;

    // 6b: reset while in LAP
    press(0);
    press(1);
    chk("t6_in_lap", 32'(dbg_state), 32'(ST_LAP));
    reset = 1'b1;
    step();
    chk_reset_vals("t6_rst_lap");
    reset = 1'b0;
    step();
    chk("t6_post_clr", 32'(cnt_clr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
